alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Parameterised N-bit signed integer ALU for the Tessia execute stage.
- Takes two N-bit operands and a 4-bit operation code, and computes the result and four status flags combinationally.
- Registers both result and flags on the rising clock edge, so they are presented one cycle after the inputs.
- Pure datapath: no handshake and no internal state beyond the output register.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- a  input  N  operand A, signed two's complement
- b  input  N  operand B, signed two's complement (unsigned shift amount for shifts)
- ctrl  input  4  operation select
- result  output  N  registered result, signed
- flags  output  4  registered status {neg, zero, carry, overflow}; bit3=neg, bit2=zero, bit1=carry, bit0=overflow

Behaviour:
- Reset: on a rising clk edge with rst=1, result<=0 and flags<=4'b0000. Reset has priority over any operation in flight, which is discarded.
- Latency: exactly 1 cycle. Inputs sampled at edge k appear on result/flags after edge k. New operation accepted every cycle.
- Opcodes (ctrl):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 XOR: a^b
  - 5 SLL: a<<b
  - 6 SRL: logical a>>b
  - 7 MUL: low N bits of signed a*b
  - 8 SRA: arithmetic a>>>b
  - 9 NOT: ~a
  - 10 MOVB: result=b
  - 11-15 reserved: result=0, carry=0, overflow=0
- Width: all results truncated to N bits.
- Shift amount: b interpreted as unsigned N-bit.
  - Amount >= N: SLL/SRL give 0; SRA gives all copies of a[N-1].
  - Amount 0: result=a.
- neg: always result[N-1].
- zero: always (result==0), including reserved opcodes, where zero=1.
- carry:
  - ADD: unsigned carry-out of bit N-1.
  - SUB: 1 when no borrow (unsigned a >= b), ARM convention.
  - SLL/SRL/SRA: last bit shifted out for amount 1..N; 0 for amount 0 or amount > N. For SRA with amount N, the bit out is a[N-1].
  - All other ops: 0.
- overflow:
  - ADD: a,b same sign and result sign differs.
  - SUB: a,b differing sign and result sign differs from a.
  - MUL: 1 when the full 2N-bit signed product is not representable in N bits.
  - All other ops: 0.
- Boundaries: the most negative value minus 1 and the most positive value plus 1 set overflow. The most negative value times -1 sets overflow for MUL.
- X-free: outputs are defined for every ctrl value.

Decomposition:
- Package alu_pkg:
  - enum alu_op_e (4-bit) naming opcodes 0-10.
  - localparams FLAG_NEG=3, FLAG_ZERO=2, FLAG_CARRY=1, FLAG_OVF=0.
- Sub-module alu_comb: purely combinational result/flags computation, parameterised by N.
- alu_unit instantiates alu_comb and adds the synchronous-reset output register.

Test Plan:
- Reset: rst=1 for 2 cycles with a=5, b=3, ctrl=ADD -> result=0, flags=0000. Release rst -> next cycle result=8, flags=0000.
- ADD/SUB overflow and carry (N=8):
  - 127+1 -> result=-128, flags=1001.
  - -1+1 -> result=0, flags=0110.
  - 5-5 -> result=0, flags=0110.
  - 3-5 -> result=-2, flags=1000.
  - -128-1 -> result=127, flags=0011.
- Logic ops (N=8):
  - 0x0F AND 0xF0 -> result=0, flags=0100.
  - 0x0F OR 0xF0 -> result=-1, flags=1000.
  - XOR of equal operands -> result=0, flags=0100.
  - NOT 0 -> result=-1, flags=1000.
- Shifts (N=8):
  - SLL 0x81 by 1 -> result=0x02, carry=1.
  - SRL 0x81 by 1 -> result=0x40, carry=1.
  - SRA 0x80 by 3 -> result=0xF0, neg=1.
  - SLL by 9 -> result=0, flags=0100.
  - SRL by 0 -> result=a, carry=0.
- MUL (N=8):
  - 10*-3 -> result=-30, flags=1000.
  - 16*16 -> result=0, flags=0101.
  - -128*-1 -> result=-128, overflow=1.
- Pipelining and reserved opcodes: back-to-back random ops each cycle, outputs checked against a reference model delayed by one cycle. ctrl=12 -> result=0, flags=0100. Assert rst mid-stream -> outputs 0 on the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum and flag bit positions shared by the ALU files
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_MUL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_NOT  = 4'd9,
        OP_MOVB = 4'd10
    } alu_op_e;
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational N-bit signed ALU result and {neg,zero,carry,overflow}
// ports: a_i, b_i operands; ctrl_i opcode; result_o result; flags_o status flags
module alu_comb
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [3:0]   ctrl_i,
    output logic [N-1:0] result_o,
    output logic [3:0]   flags_o
);
    localparam logic [N-1:0] N_AMT = N[N-1:0];
    logic [N:0]     sum, diff;
    logic [2*N-1:0] sll_w, srl_w, sra_w, prod;
    logic [N-1:0]   res;
    logic           c, v;
    // Shifting through a double-width window keeps the last bit shifted out
    // next to the result: just above it for SLL, just below it for SRL/SRA.
    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    assign sll_w = {{N{1'b0}}, a_i} << b_i;
    assign srl_w = {a_i, {N{1'b0}}} >> b_i;
    assign sra_w = $signed({a_i, {N{1'b0}}}) >>> b_i;
    assign prod  = $signed({{N{a_i[N-1]}}, a_i}) * $signed({{N{b_i[N-1]}}, b_i});
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (ctrl_i)
            OP_ADD: begin
                res = sum[N-1:0];
                c   = sum[N];
                v   = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            OP_SUB: begin
                res = diff[N-1:0];
                c   = ~diff[N];
                v   = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
            end
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_SLL: begin
                res = sll_w[N-1:0];
                c   = sll_w[N];
            end
            OP_SRL: begin
                res = srl_w[2*N-1:N];
                c   = srl_w[N-1];
            end
            OP_SRA: begin
                res = sra_w[2*N-1:N];
                // sign fill keeps feeding this bit past N, so cap it there
                c   = (b_i <= N_AMT) & sra_w[N-1];
            end
            OP_MUL: begin
                res = prod[N-1:0];
                v   = prod[2*N-1:N-1] != {(N+1){prod[N-1]}};
            end
            OP_NOT:  res = ~a_i;
            OP_MOVB: res = b_i;
            default: res = '0;
        endcase
    end
    assign result_o = res;
    always_comb begin
        flags_o             = '0;
        flags_o[FLAG_NEG]   = res[N-1];
        flags_o[FLAG_ZERO]  = res == '0;
        flags_o[FLAG_CARRY] = c;
        flags_o[FLAG_OVF]   = v;
    end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: registered N-bit signed ALU, one-cycle latency
// ports: clk, rst (sync, active-high); a, b operands; ctrl opcode;
//        result registered result; flags registered {neg,zero,carry,overflow}
module alu_unit
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ctrl,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);
    logic [N-1:0] result_d, result_q;
    logic [3:0]   flags_d, flags_q;
    alu_comb #(.N(N)) u_comb (
        .a_i     (a),
        .b_i     (b),
        .ctrl_i  (ctrl),
        .result_o(result_d),
        .flags_o (flags_d)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end
    assign result = result_q;
    assign flags  = flags_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and model-checked stimulus for alu_unit (N=8)
module tb_alu_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic [3:0] ctrl;
    logic [7:0] result;
    logic [3:0] flags;
    int checks = 0;
    int errors = 0;

    alu_unit #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .result(result),
        .flags (flags)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] op);
        int ua = int'(x);
        int ub = int'(y);
        int sa = int'($signed(x));
        int sb = int'($signed(y));
        int r = 0;
        int p;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [7:0] res;
        case (op)
            4'd0: begin r = ua + ub; c = r > 255; p = sa + sb; v = p > 127 || p < -128; end
            4'd1: begin r = ua - ub; c = ua >= ub; p = sa - sb; v = p > 127 || p < -128; end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: begin r = ub >= 8 ? 0 : ua << ub; c = (ub >= 1 && ub <= 8) ? ((ua >> (8 - ub)) & 1) != 0 : 1'b0; end
            4'd6: begin r = ub >= 8 ? 0 : ua >> ub; c = (ub >= 1 && ub <= 8) ? ((ua >> (ub - 1)) & 1) != 0 : 1'b0; end
            4'd7: begin p = sa * sb; r = p; v = p > 127 || p < -128; end
            4'd8: begin r = ub >= 8 ? (sa < 0 ? -1 : 0) : sa >>> ub; c = (ub >= 1 && ub <= 8) ? ((ua >> (ub - 1)) & 1) != 0 : 1'b0; end
            4'd9: r = ~ua;
            4'd10: r = ub;
            default: r = 0;
        endcase
        res = r[7:0];
        return {res[7], res == 8'h00, c, v, res};
    endfunction

    task automatic chk(input string tag, input logic [7:0] er, input logic [3:0] ef);
        checks++;
        assert (result === er) else begin
            errors++;
            $error("FAIL %s result got %h expected %h", tag, result, er);
        end
        checks++;
        assert (flags === ef) else begin
            errors++;
            $error("FAIL %s flags got %b expected %b", tag, flags, ef);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [3:0] op,
                        input logic [7:0] er, input logic [3:0] ef);
        a = x;
        b = y;
        ctrl = op;
        @(posedge clk);
        #1;
        chk(tag, er, ef);
    endtask

    initial begin
        logic [11:0] e;
        logic [7:0]  rx, ry;
        logic [3:0]  rop;
        rst = 1'b1;
        step("rst0", 8'd5, 8'd3, 4'd0, 8'h00, 4'b0000);
        step("rst1", 8'd5, 8'd3, 4'd0, 8'h00, 4'b0000);
        rst = 1'b0;
        step("rst_rel", 8'd5, 8'd3, 4'd0, 8'h08, 4'b0000);
        step("add_max", 8'h7F, 8'h01, 4'd0, 8'h80, 4'b1001);
        step("add_m1p1", 8'hFF, 8'h01, 4'd0, 8'h00, 4'b0110);
        step("sub_eq", 8'd5, 8'd5, 4'd1, 8'h00, 4'b0110);
        step("sub_neg", 8'd3, 8'd5, 4'd1, 8'hFE, 4'b1000);
        step("sub_min", 8'h80, 8'h01, 4'd1, 8'h7F, 4'b0011);
        step("and", 8'h0F, 8'hF0, 4'd2, 8'h00, 4'b0100);
        step("or", 8'h0F, 8'hF0, 4'd3, 8'hFF, 4'b1000);
        step("xor_eq", 8'h5A, 8'h5A, 4'd4, 8'h00, 4'b0100);
        step("not0", 8'h00, 8'h33, 4'd9, 8'hFF, 4'b1000);
        step("sll1", 8'h81, 8'd1, 4'd5, 8'h02, 4'b0010);
        step("srl1", 8'h81, 8'd1, 4'd6, 8'h40, 4'b0010);
        step("sra3", 8'h80, 8'd3, 4'd8, 8'hF0, 4'b1000);
        step("sll9", 8'hFF, 8'd9, 4'd5, 8'h00, 4'b0100);
        step("srl0", 8'h81, 8'd0, 4'd6, 8'h81, 4'b1000);
        step("sll8", 8'h01, 8'd8, 4'd5, 8'h00, 4'b0110);
        step("sra8", 8'h80, 8'd8, 4'd8, 8'hFF, 4'b1010);
        step("sra9", 8'h80, 8'd9, 4'd8, 8'hFF, 4'b1000);
        step("srl8", 8'h80, 8'd8, 4'd6, 8'h00, 4'b0110);
        step("mul_neg", 8'd10, 8'hFD, 4'd7, 8'hE2, 4'b1000);
        step("mul_ovf", 8'd16, 8'd16, 4'd7, 8'h00, 4'b0101);
        step("mul_min", 8'h80, 8'hFF, 4'd7, 8'h80, 4'b1001);
        step("movb", 8'h11, 8'h80, 4'd10, 8'h80, 4'b1000);
        step("rsv12", 8'd5, 8'd3, 4'd12, 8'h00, 4'b0100);
        step("rsv15", 8'hFF, 8'hFF, 4'd15, 8'h00, 4'b0100);
        for (int i = 0; i < 60; i++) begin
            rx  = 8'($urandom);
            rop = 4'($urandom_range(0, 15));
            ry  = (rop == 4'd5 || rop == 4'd6 || rop == 4'd8) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            e   = model(rx, ry, rop);
            step("rand", rx, ry, rop, e[7:0], e[11:8]);
        end
        step("pre_rst", 8'd100, 8'd27, 4'd0, 8'h7F, 4'b0000);
        rst = 1'b1;
        step("mid_rst", 8'h7F, 8'h01, 4'd0, 8'h00, 4'b0000);
        rst = 1'b0;
        step("post_rst", 8'h40, 8'h40, 4'd0, 8'h80, 4'b1001);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
